// File: rtl/retire_stage.sv
// In-order commit unit: retires the ROB head entry, updating the arch map and free list,
// issuing stores via a request/grant handshake, redirecting fetch on taken branches and latching halt.
module retire_stage #(
  parameter int XLEN  = 32,
  parameter int PR_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             head_complete,
  input  logic             head_t_valid,
  input  logic [PR_W-1:0]  head_t_idx,
  input  logic             head_t_old_valid,
  input  logic [PR_W-1:0]  head_t_old_idx,
  input  logic             head_halt,
  input  logic             head_wr_mem,
  input  logic [4:0]       head_dest_reg,
  input  logic [XLEN-1:0]  head_npc,
  input  logic [XLEN-1:0]  head_result,
  input  logic [XLEN-1:0]  head_rs2_value,
  input  logic             head_take_branch,
  output logic             retire_ack,
  output logic             amt_we,
  output logic [4:0]       amt_idx,
  output logic [PR_W-1:0]  amt_tag,
  output logic             fl_free_en,
  output logic [PR_W-1:0]  fl_free_tag,
  output logic             mem_req,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_gnt,
  output logic             squash,
  output logic [XLEN-1:0]  squash_pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  // state      | meaning
  // RUN        | retiring heads; stores leave for STORE_WAIT
  // STORE_WAIT | store request outstanding, head held until mem_gnt
  // HALTED     | halt retired; nothing more commits until reset
  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] STORE_WAIT = 2'd1;
  localparam logic [1:0] HALTED     = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       ack_raw;
  logic       issue_store;
  logic       set_squash;
  logic       npc_unused;

  // The link value was already written by the execute stage; PC+4 is not needed here.
  assign npc_unused = ^head_npc;

  always_comb begin
    state_nxt   = state;
    ack_raw     = 1'b0;
    issue_store = 1'b0;
    case (state)
      RUN: begin
        // The flush cycle blocks retirement of whatever now sits at the head.
        if (head_complete && !squash) begin
          if (head_halt) begin
            ack_raw   = 1'b1;
            state_nxt = HALTED;
          end else if (head_wr_mem) begin
            issue_store = 1'b1;
            state_nxt   = STORE_WAIT;
          end else begin
            ack_raw = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        if (mem_gnt) begin
          ack_raw   = 1'b1;
          state_nxt = RUN;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Gating with reset keeps every combinational output at zero while reset is held.
  assign retire_ack  = ack_raw & reset;
  assign amt_we      = retire_ack & head_t_valid & (head_dest_reg != 5'd0);
  assign amt_idx     = retire_ack ? head_dest_reg : 5'd0;
  assign amt_tag     = retire_ack ? head_t_idx : '0;
  assign fl_free_en  = retire_ack & head_t_old_valid;
  assign fl_free_tag = retire_ack ? head_t_old_idx : '0;

  assign set_squash  = retire_ack & head_take_branch & ~head_halt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      squash        <= 1'b0;
      squash_pc     <= '0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      state  <= state_nxt;
      squash <= set_squash;
      if (set_squash) begin
        squash_pc <= head_result;
      end
      if (retire_ack) begin
        retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state == RUN && state_nxt == HALTED) begin
        halted <= 1'b1;
      end
      if (issue_store) begin
        mem_req   <= 1'b1;
        mem_addr  <= head_result;
        mem_wdata <= head_rs2_value;
      end else if (state == STORE_WAIT && mem_gnt) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule
